// File: rtl/result_disp_seq.sv
// rtl/result_disp_seq.sv - plays last/best reaction-time results on one 7-segment digit
module result_disp_seq #(
  parameter int DIGIT_CYC = 20000000,
  parameter int GAP_CYC   = 4000000,
  parameter int CNT_W     = 25
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_last,
  input  logic [23:0] i_best,
  input  logic        i_req,
  input  logic        i_abort,
  output logic [6:0]  o_seg,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(DIGIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic             NO_GAP    = (GAP_CYC == 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [23:0]      last_q, best_q;
  logic [1:0]       part;      // 0: "L", 1: last digits, 2: "b", 3: best digits
  logic [2:0]       nib;
  logic [1:0]       nxt_part;
  logic [2:0]       nxt_nib;
  logic             seq_end;
  logic             adv;
  logic [6:0]       nxt_glyph;

  // Index of the first nibble to show; an all-F field starts at nibble 0 so it yields one "-".
  function automatic logic [2:0] first_idx(input logic [23:0] x);
    logic [2:0] r;
    r = 3'd0;
    if (x != 24'hFFFFFF)
      for (int i = 1; i < 6; i++)
        if (x[i*4 +: 4] != 4'h0) r = 3'(i);
    return r;
  endfunction

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  always_comb begin
    nxt_part  = part;
    nxt_nib   = nib;
    seq_end   = 1'b0;
    nxt_glyph = 7'h00;
    case (part)
      2'd0: begin
        nxt_part = 2'd1;
        nxt_nib  = first_idx(last_q);
      end
      2'd1: begin
        if (nib == 3'd0) begin
          nxt_part = 2'd2;
          nxt_nib  = 3'd0;
        end else begin
          nxt_nib = nib - 3'd1;
        end
      end
      2'd2: begin
        nxt_part = 2'd3;
        nxt_nib  = first_idx(best_q);
      end
      default: begin
        if (nib == 3'd0) seq_end = 1'b1;
        else             nxt_nib = nib - 3'd1;
      end
    endcase
    case (nxt_part)
      2'd0:    nxt_glyph = 7'h38;
      2'd1:    nxt_glyph = digit_glyph(last_q[{nxt_nib, 2'b00} +: 4]);
      2'd2:    nxt_glyph = 7'h7C;
      default: nxt_glyph = digit_glyph(best_q[{nxt_nib, 2'b00} +: 4]);
    endcase
  end

  assign adv = ((state == SHOW) && (cnt == SHOW_LAST) && NO_GAP) ||
               ((state == GAP)  && (cnt == GAP_LAST));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last_q <= '0;
      best_q <= '0;
      part   <= 2'd0;
      nib    <= 3'd0;
      o_seg  <= 7'h00;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else if (i_abort) begin
      state  <= IDLE;
      cnt    <= '0;
      o_seg  <= 7'h00;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            last_q <= i_last;
            best_q <= i_best;
            part   <= 2'd0;
            nib    <= 3'd0;
            cnt    <= '0;
            state  <= SHOW;
            o_seg  <= 7'h38;
            o_busy <= 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt <= '0;
            if (!NO_GAP) begin
              state <= GAP;
              o_seg <= 7'h00;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) cnt <= '0;
          else                 cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (adv) begin
        if (seq_end) begin
          state  <= IDLE;
          o_seg  <= 7'h00;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end else begin
          state <= SHOW;
          part  <= nxt_part;
          nib   <= nxt_nib;
          o_seg <= nxt_glyph;
        end
      end
    end
  end

endmodule
